gcd_engine: RTL and testbench

- Parametrised iterative GCD engine: the WIDTH-generic successor of the 8-bit GCD block.
- Uses binary (Stein) GCD: shift/subtract only, no modulo operator. Bounded, data-dependent latency.
- valid/ready handshake on both input and output, so it sits directly in a streaming datapath with backpressure.
- Optional LCM post-stage via a sequential divider.

---
 rtl/gcd_engine_if.sv | 27 ++
 rtl/gcd_engine.sv | 155 +++++++++++++++
 tb/tb_gcd_engine.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gcd_engine_if.sv
// gcd_engine_if -- operand/result handshake bundle for gcd_engine.
//   in_valid/in_ready : operand pair handshake (a, b)
//   out_valid/out_ready: result handshake (gcd_out, lcm_out)
//   lcm_out exists only when GCD_LCM_EN is defined.
// Modports: master = producer/consumer around the engine, slave = engine.
interface gcd_engine_if #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   gcd_out;
`ifdef GCD_LCM_EN
  logic [2*WIDTH-1:0] lcm_out;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, gcd_out, lcm_out);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, gcd_out, lcm_out);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, gcd_out);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, gcd_out);
`endif
endinterface

// File: rtl/gcd_engine.sv
// gcd_engine -- iterative binary (Stein) GCD with valid/ready on both sides.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any in-flight operation
//   bus   : gcd_engine_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/
//           gcd_out[/lcm_out])
// Optional: define GCD_LCM_EN to add a restoring divider (a / gcd, WIDTH
// cycles) and a multiply stage producing lcm_out = (a/gcd)*b.
module gcd_engine #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  gcd_engine_if.slave  bus
);

`ifdef GCD_LCM_EN
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_REDUCE, S_DIV, S_MUL, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_REDUCE, S_DONE} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_x, r_y;
  logic [SHW-1:0]   r_k;
  logic             r_in_ready, r_out_valid;
  logic [WIDTH-1:0] r_gcd;

  logic [WIDTH-1:0] w_xmy, w_ymx, w_res;
  assign w_xmy = r_x - r_y;
  assign w_ymx = r_y - r_x;
  // common power of two restored; cannot overflow since it divides a and b
  assign w_res = r_x << r_k;

`ifdef GCD_LCM_EN
  logic [WIDTH-1:0]   r_a, r_b, r_g;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_lcm;

  // Divider reuses x as dividend/quotient shift register and y as remainder.
  // Remainder stays below g, so the shifted remainder needs one extra bit and
  // the subtraction result always fits back into WIDTH bits.
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_prod;
  assign w_rem_sh  = {r_y, r_x[WIDTH-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_g};
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_g;
  assign w_prod    = {{WIDTH{1'b0}}, r_x} * {{WIDTH{1'b0}}, r_b};
  assign bus.lcm_out = r_lcm;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.gcd_out   = r_gcd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_gcd       <= '0;
`ifdef GCD_LCM_EN
      r_a   <= '0;
      r_b   <= '0;
      r_g   <= '0;
      r_cnt <= '0;
      r_lcm <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_in_ready <= 1'b0;
          r_x        <= bus.a;
          r_y        <= bus.b;
          r_k        <= '0;
`ifdef GCD_LCM_EN
          r_a <= bus.a;
          r_b <= bus.b;
`endif
          if (bus.a == '0 || bus.b == '0) begin
            // lcm_out is already 0 here, so DIV/MUL are skipped
            r_gcd       <= bus.a | bus.b;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (!r_x[0] && !r_y[0]) begin
            r_x <= r_x >> 1;
            r_y <= r_y >> 1;
            r_k <= r_k + SHW'(1);
          end else begin
            r_state <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (r_x == r_y) begin
`ifdef GCD_LCM_EN
            r_g     <= w_res;
            r_x     <= r_a;
            r_y     <= '0;
            r_cnt   <= '0;
            r_state <= S_DIV;
`else
            r_gcd       <= w_res;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`endif
          end else if (!r_x[0]) begin
            r_x <= r_x >> 1;
          end else if (!r_y[0]) begin
            r_y <= r_y >> 1;
          end else if (r_x > r_y) begin
            // both odd: difference is even, halve it in the same step
            r_x <= w_xmy >> 1;
          end else begin
            r_y <= w_ymx >> 1;
          end
        end
`ifdef GCD_LCM_EN
        S_DIV: begin
          r_x   <= {r_x[WIDTH-2:0], w_ge};
          r_y   <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
          r_cnt <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(WIDTH - 1)) r_state <= S_MUL;
        end
        S_MUL: begin
          r_lcm       <= w_prod;
          r_gcd       <= r_g;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
`endif
        S_DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_gcd       <= '0;
          r_in_ready  <= 1'b1;
`ifdef GCD_LCM_EN
          r_lcm <= '0;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine -- directed self-checking bench for gcd_engine.
// Builds with WIDTH=8 by default, WIDTH=16 plus LCM checks with GCD_LCM_EN.
module tb_gcd_engine;
`ifdef GCD_LCM_EN
  localparam int W     = 16;
  localparam int BOUND = 3*W + 4;
`else
  localparam int W     = 8;
  localparam int BOUND = 2*W + 2;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  gcd_engine_if #(.WIDTH(W)) ifc ();

  gcd_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a pair (caller is idle, just past an edge), wait for out_valid.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, output int lat);
    ifc.in_valid = 1'b1;
    ifc.a = ta;
    ifc.b = tb;
    step();
    ifc.in_valid = 1'b0;
    ifc.a = ~ta;            // later operand changes must be ignored
    ifc.b = ~tb;
    lat = 1;
    while (!ifc.out_valid && lat <= BOUND) begin
      step();
      lat++;
    end
  endtask

  // Full transaction with out_ready=1; checks latency, result and release.
  task automatic run(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic [W-1:0] eg);
    int lat;
    ifc.out_ready = 1'b1;
    chk({tag, ".in_ready"}, ifc.in_ready, 1);
    issue(ta, tb, lat);
    if (ta == '0 || tb == '0) chk({tag, ".lat_exact"}, lat, 1);
    else                      chk({tag, ".lat_bound"}, lat <= BOUND, 1);
    chk({tag, ".gcd"}, ifc.gcd_out, eg);
    step();
    chk({tag, ".rel_valid"}, ifc.out_valid, 0);
    chk({tag, ".rel_gcd"}, ifc.gcd_out, 0);
    chk({tag, ".rel_ready"}, ifc.in_ready, 1);
  endtask

`ifdef GCD_LCM_EN
  task automatic run_lcm(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] eg, input logic [2*W-1:0] el);
    int lat;
    ifc.out_ready = 1'b0;
    issue(ta, tb, lat);
    chk({tag, ".lat"}, lat <= BOUND, 1);
    chk({tag, ".gcd"}, ifc.gcd_out, eg);
    chk({tag, ".lcm"}, ifc.lcm_out, el);
    ifc.out_ready = 1'b1;
    step();
    chk({tag, ".rel_lcm"}, ifc.lcm_out, 0);
    chk({tag, ".rel_ready"}, ifc.in_ready, 1);
  endtask
`endif

  initial begin
    int lat;
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.out_ready = 1'b1;
    step();
    step();
    chk("rst.in_ready", ifc.in_ready, 1);
    chk("rst.out_valid", ifc.out_valid, 0);
    chk("rst.gcd", ifc.gcd_out, 0);
`ifdef GCD_LCM_EN
    chk("rst.lcm", ifc.lcm_out, 0);
`endif
    reset = 1'b0;
    step();

    run("g48_18", W'(48), W'(18), W'(6));
    run("g0_35", W'(0), W'(35), W'(35));
    run("g0_0", W'(0), W'(0), W'(0));
    run("g255", W'(255), W'(255), W'(255));
    run("g128_64", W'(128), W'(64), W'(64));
    run("g17_5", W'(17), W'(5), W'(1));
    run("gones", {W{1'b1}}, W'(3), W'(3));

    // backpressure: result held, engine busy, new pairs ignored
    ifc.out_ready = 1'b0;
    issue(W'(21), W'(14), lat);
    chk("bp.lat", lat <= BOUND, 1);
    for (int i = 0; i < 10; i++) begin
      ifc.in_valid = 1'b1;
      ifc.a = W'(9);
      ifc.b = W'(6);
      chk("bp.valid", ifc.out_valid, 1);
      chk("bp.gcd", ifc.gcd_out, 7);
      chk("bp.in_ready", ifc.in_ready, 0);
      step();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    step();
    chk("bp.rel_valid", ifc.out_valid, 0);
    chk("bp.rel_ready", ifc.in_ready, 1);
    step();
    chk("bp.no_stale", ifc.out_valid, 0);

    // reset in the middle of a computation
    ifc.in_valid = 1'b1;
    ifc.a = W'(200);
    ifc.b = W'(150);
    step();
    ifc.in_valid = 1'b0;
    chk("mid.busy", ifc.in_ready, 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid.out_valid", ifc.out_valid, 0);
    chk("mid.in_ready", ifc.in_ready, 1);
    chk("mid.gcd", ifc.gcd_out, 0);
    reset = 1'b0;
    step();
    chk("mid.idle", ifc.out_valid, 0);
    run("g9_6", W'(9), W'(6), W'(3));

`ifdef GCD_LCM_EN
    run_lcm("l40k", W'(40000), W'(30000), W'(10000), (2*W)'(120000));
    run_lcm("l4_6", W'(4), W'(6), W'(2), (2*W)'(12));
    run_lcm("l0_7", W'(0), W'(7), W'(7), (2*W)'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
